// File: rtl/ecg_pkg.sv
// Shared widths and defaults for the QRS detection chain.
// Width helpers keep every stage consistent with the sample width chosen upstream.
package ecg_pkg;

   localparam int MWI_WIN_LOG2 = 5;

   // A signed square needs one bit less than the full product; (-2^(w-1))^2 still fits.
   function automatic int sq_w(input int data_w);
      return 2 * data_w - 1;
   endfunction

   function automatic int sum_w(input int data_w, input int win_log2);
      return sq_w(data_w) + win_log2;
   endfunction

endpackage

// File: rtl/axis_moving_window_integrator_if.sv
// Sample-in / mean-out stream bundle for the moving-window integrator.
// The output side has no back-pressure.
interface axis_moving_window_integrator_if #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 32
);

   logic                     s_axis_tvalid;
   logic                     s_axis_tready;
   logic signed [DATA_W-1:0] s_axis_tdata;
   logic                     m_axis_tvalid;
   logic [OUT_W-1:0]         m_axis_tdata;

   modport slave (
      input  s_axis_tvalid,
      input  s_axis_tdata,
      output s_axis_tready,
      output m_axis_tvalid,
      output m_axis_tdata
   );

   modport master (
      output s_axis_tvalid,
      output s_axis_tdata,
      input  s_axis_tready,
      input  m_axis_tvalid,
      input  m_axis_tdata
   );

endinterface

// File: rtl/mwi_delay_line.sv
// Circular buffer of the last N squares with a read-first port.
// The oldest entry reads as zero until the window has filled, so storage needs no reset.
module mwi_delay_line
   import ecg_pkg::*;
#(
   parameter int SQ_W     = 31,
   parameter int WIN_LOG2 = MWI_WIN_LOG2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [SQ_W-1:0] wr_data,
   output logic [SQ_W-1:0] old,
   output logic            full
);

   localparam int N = 1 << WIN_LOG2;
   localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2 + 1)'(N);

   logic [SQ_W-1:0]     mem [N];
   logic [WIN_LOG2-1:0] wr_ptr_reg;
   logic [WIN_LOG2:0]   fill_reg;

   assign full = (fill_reg == FILL_MAX);
   assign old  = full ? mem[wr_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         fill_reg   <= '0;
      end else if (wr_en) begin
         wr_ptr_reg <= wr_ptr_reg + WIN_LOG2'(1);
         if (!full) begin
            fill_reg <= fill_reg + (WIN_LOG2 + 1)'(1);
         end
      end
   end

endmodule

// File: rtl/axis_moving_window_integrator.sv
// Squares each derivative sample and emits the mean of the last 2^WIN_LOG2 squares.
// Three-stage pipeline: square, accumulate, mean/saturate; one sample per clock.
module axis_moving_window_integrator
   import ecg_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int WIN_LOG2 = MWI_WIN_LOG2,
   parameter int OUT_W    = 32
) (
   input logic                            clk,
   input logic                            rst_n,
   axis_moving_window_integrator_if.slave bus
);

   localparam int SQ_W  = sq_w(DATA_W);
   localparam int SUM_W = sum_w(DATA_W, WIN_LOG2);

   logic                   tready_reg;
   logic                   v1_reg;
   logic                   v2_reg;
   logic                   m_valid_reg;
   logic [OUT_W-1:0]       m_data_reg;
   logic [SQ_W-1:0]        sq_reg;
   logic [SQ_W-1:0]        sq_next;
   logic signed [SQ_W-1:0] x_ext;
   logic [SQ_W-1:0]        old;
   logic                   full;
   logic [SUM_W-1:0]       sum_reg;
   logic [OUT_W-1:0]       mean_sat;
   logic                   accept;

   assign accept  = bus.s_axis_tvalid && tready_reg;
   assign x_ext   = SQ_W'(bus.s_axis_tdata);
   assign sq_next = x_ext * x_ext;

   assign bus.s_axis_tready = tready_reg;
   assign bus.m_axis_tvalid = m_valid_reg;
   assign bus.m_axis_tdata  = m_data_reg;

   mwi_delay_line #(
      .SQ_W     (SQ_W),
      .WIN_LOG2 (WIN_LOG2)
   ) u_delay_line (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (v1_reg),
      .wr_data (sq_reg),
      .old     (old),
      .full    (full)
   );

   // Saturation logic only exists when the mean can be wider than the output.
   generate
      if (SUM_W - WIN_LOG2 <= OUT_W) begin : g_no_sat
         assign mean_sat = OUT_W'(sum_reg >> WIN_LOG2);
      end else begin : g_sat
         logic [SUM_W-1:0] mean_full;
         assign mean_full = sum_reg >> WIN_LOG2;
         assign mean_sat  = (mean_full > SUM_W'({OUT_W{1'b1}})) ? '1 : OUT_W'(mean_full);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tready_reg  <= 1'b0;
         sq_reg      <= '0;
         v1_reg      <= 1'b0;
         sum_reg     <= '0;
         v2_reg      <= 1'b0;
         m_valid_reg <= 1'b0;
         m_data_reg  <= '0;
      end else begin
         tready_reg <= 1'b1;

         v1_reg <= accept;
         if (accept) begin
            sq_reg <= sq_next;
         end

         // The sum never exceeds N * max(sq), so SUM_W cannot overflow or underflow.
         v2_reg <= v1_reg;
         if (v1_reg) begin
            if (full) begin
               sum_reg <= sum_reg + SUM_W'(sq_reg) - SUM_W'(old);
            end else begin
               sum_reg <= sum_reg + SUM_W'(sq_reg);
            end
         end

         m_valid_reg <= v2_reg;
         if (v2_reg) begin
            m_data_reg <= mean_sat;
         end
      end
   end

endmodule

// File: tb/tb_axis_moving_window_integrator.sv
// Scoreboard bench for the moving-window integrator: a direct windowed-sum model
// predicts each mean and the edge it must appear on.
module tb_axis_moving_window_integrator;
   import ecg_pkg::*;

   localparam int DATA_W   = 16;
   localparam int WIN_LOG2 = MWI_WIN_LOG2;
   localparam int OUT_W    = 32;
   localparam int N        = 1 << WIN_LOG2;

   typedef struct {
      longint value;
      longint edge_no;
   } exp_t;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b0;
   longint cyc   = 0;
   exp_t   exp_q[$];
   longint hist[$];
   int     n_checks = 0;
   int     n_pass   = 0;
   int     n_out    = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   axis_moving_window_integrator_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

   axis_moving_window_integrator #(
      .DATA_W   (DATA_W),
      .WIN_LOG2 (WIN_LOG2),
      .OUT_W    (OUT_W)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check_eq(input string tag, input longint got, input longint expected);
      n_checks++;
      if (got == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, expected);
   endtask

   // Reference: explicit sum over the zero-padded last N squares.
   function automatic longint model_push(input int x);
      longint sq, acc, mean, lim;
      sq = longint'(x) * longint'(x);
      hist.push_back(sq);
      if (hist.size() > N) void'(hist.pop_front());
      acc = 0;
      foreach (hist[i]) acc += hist[i];
      mean = acc / N;
      lim  = (longint'(1) <<< OUT_W) - 1;
      return (mean > lim) ? lim : mean;
   endfunction

   task automatic send(input int x);
      int   tries;
      exp_t e;
      @(negedge clk);
      bus.s_axis_tvalid = 1'b1;
      bus.s_axis_tdata  = x[DATA_W-1:0];
      tries = 0;
      while (!bus.s_axis_tready && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      if (tries == 20) check_eq("tready_timeout", 0, 1);
      e.value   = model_push(x);
      e.edge_no = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.s_axis_tvalid = 1'b0;
      end
   endtask

   task automatic drain();
      int waited;
      idle(1);
      waited = 0;
      while (exp_q.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check_eq("drain_empty", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      bus.s_axis_tvalid = 1'b0;
      exp_q.delete();
      hist.delete();
      #1;
      check_eq("rst_m_tvalid", bus.m_axis_tvalid, 0);
      check_eq("rst_tready", bus.s_axis_tready, 0);
      check_eq("rst_m_tdata", bus.m_axis_tdata, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("tready_after_rst", bus.s_axis_tready, 1);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.m_axis_tvalid) begin
         n_out++;
         $display("out %0d edge=%0d data=%0d", n_out, cyc, bus.m_axis_tdata);
         if (exp_q.size() == 0) begin
            check_eq("stray_pulse", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check_eq("mean", longint'(bus.m_axis_tdata), e.value);
            check_eq("latency_edge", cyc, e.edge_no + 2);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tdata  = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("init_tready", bus.s_axis_tready, 0);
      check_eq("init_m_tvalid", bus.m_axis_tvalid, 0);
      check_eq("init_m_tdata", bus.m_axis_tdata, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("tready_first_edge", bus.s_axis_tready, 1);

      // Constant step, one sample every 3 clocks.
      for (int i = 0; i < 40; i++) begin
         send(4);
         idle(2);
      end
      drain();
      do_reset();

      // Sign invariance.
      for (int i = 0; i < 40; i++) begin
         send(-4);
         idle(2);
      end
      drain();
      do_reset();

      // Full scale, back-to-back.
      for (int i = 0; i < 40; i++) send(-32768);
      drain();
      do_reset();

      // Alternating +-1 across several pointer wraps.
      for (int i = 0; i < 100; i++) send((i % 2 == 0) ? 1 : -1);
      drain();
      do_reset();

      // Window exit: 8s then zeros.
      for (int i = 0; i < 32; i++) send(8);
      for (int i = 0; i < 32; i++) send(0);
      drain();

      // Reset with samples still in flight.
      do_reset();
      for (int i = 0; i < 6; i++) send(4);
      do_reset();
      send(4);
      send(4);
      drain();
      idle(5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
